bkram_sd_ctrl: RTL

// - Sequences backup-RAM (BRAM) save/load between the dual-port BRAM port B and the HPS SD sector interface.
// - Transfers one save slot per request: 16 sectors of 256 x 16-bit words.
// - Formats BRAM with the HuC "HUBM" header and owns the port-B address/data/write mux.
// - Sits in the emu top between hps_io (sd_*) and the backram_l/backram_h dpram pair; loading holds the core in reset.

---
 rtl/bkram_pkg.sv | 17 +
 rtl/bkram_sd_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bkram_pkg.sv
// rtl/bkram_pkg.sv - shared types and constants for the backup-RAM SD sequencer
package bkram_pkg;

  localparam int SECT_BITS_DEF = 4;
  localparam int SLOT_BITS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    FMT
  } bk_state_t;

  // HuC "HUBM" backup-RAM header written by a format
  localparam logic [15:0] HUBM_DEF [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

endpackage

// File: rtl/bkram_sd_ctrl.sv
// rtl/bkram_sd_ctrl.sv - BRAM port-B save/load/format sequencer against the hps_io SD sector interface
// Optional dirty tracking: define BKRAM_DIRTY_EN.
module bkram_sd_ctrl
  import bkram_pkg::*;
#(
  parameter int SECT_BITS = SECT_BITS_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int BRAM_AW   = SECT_BITS + 8
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 bk_ena,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic                 format_req,
  input  logic [SLOT_BITS-1:0] slot,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  input  logic [7:0]           sd_buff_addr,
  input  logic [15:0]          sd_buff_dout,
  input  logic                 sd_buff_wr,
  output logic [BRAM_AW-1:0]   bram_b_addr,
  output logic [15:0]          bram_b_data,
  output logic                 bram_b_we,
`ifdef BKRAM_DIRTY_EN
  input  logic                 bram_core_we,
  output logic                 dirty,
`endif
  output logic                 busy,
  output logic                 loading
);

  bk_state_t   state, state_n;
  logic [31:0] lba_n;
  logic        rd_n, wr_n, busy_n, loading_n;
  logic [1:0]  fmt_idx, idx_n;
  logic        load_prev, save_prev, fmt_prev, ack_prev;
  logic        load_edge, save_edge, fmt_edge, ack_rise, ack_fall;
  logic        save_ok;
  logic        last_sect;

  assign load_edge = load_req & ~load_prev;
  assign save_edge = save_req & ~save_prev;
  assign fmt_edge  = format_req & ~fmt_prev;
  assign ack_rise  = sd_ack & ~ack_prev;
  assign ack_fall  = ~sd_ack & ack_prev;
  assign last_sect = &sd_lba[SECT_BITS-1:0];

`ifdef BKRAM_DIRTY_EN
  assign save_ok = dirty;
`else
  assign save_ok = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sd_lba    <= '0;
      sd_rd     <= 1'b0;
      sd_wr     <= 1'b0;
      busy      <= 1'b0;
      loading   <= 1'b0;
      fmt_idx   <= '0;
      load_prev <= 1'b0;
      save_prev <= 1'b0;
      fmt_prev  <= 1'b0;
      ack_prev  <= 1'b0;
    end else begin
      state     <= state_n;
      sd_lba    <= lba_n;
      sd_rd     <= rd_n;
      sd_wr     <= wr_n;
      busy      <= busy_n;
      loading   <= loading_n;
      fmt_idx   <= idx_n;
      load_prev <= load_req;
      save_prev <= save_req;
      fmt_prev  <= format_req;
      ack_prev  <= sd_ack;
    end
  end

  always_comb begin
    state_n   = state;
    lba_n     = sd_lba;
    rd_n      = sd_rd;
    wr_n      = sd_wr;
    busy_n    = busy;
    loading_n = loading;
    idx_n     = fmt_idx;
    case (state)
      IDLE: begin
        if ((load_edge || (save_edge && save_ok)) && bk_ena) begin
          state_n   = REQ;
          lba_n     = '0;
          lba_n[SECT_BITS +: SLOT_BITS] = slot;
          rd_n      = load_edge;
          wr_n      = ~load_edge;
          busy_n    = 1'b1;
          loading_n = load_edge;
        end else if (fmt_edge) begin
          state_n = FMT;
          idx_n   = '0;
          busy_n  = 1'b1;
        end
      end
      REQ: begin
        if (ack_rise) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          if (last_sect) begin
            state_n   = IDLE;
            busy_n    = 1'b0;
            loading_n = 1'b0;
          end else begin
            // Only the sector field advances; the slot field never carries
            lba_n[SECT_BITS-1:0] = SECT_BITS'(sd_lba[SECT_BITS-1:0] + 1'b1);
            rd_n    = loading;
            wr_n    = ~loading;
            state_n = REQ;
          end
        end
      end
      FMT: begin
        idx_n = fmt_idx + 2'd1;
        if (fmt_idx == 2'd3) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bram_b_addr = {sd_lba[SECT_BITS-1:0], sd_buff_addr};
    bram_b_data = sd_buff_dout;
    bram_b_we   = sd_buff_wr & sd_ack & loading;
    if (state == FMT) begin
      bram_b_addr = BRAM_AW'(fmt_idx);
      bram_b_data = HUBM_DEF[fmt_idx];
      bram_b_we   = 1'b1;
    end
  end

`ifdef BKRAM_DIRTY_EN
  logic xfer_done, fmt_done;
  assign xfer_done = (state == XFER) && ack_fall && last_sect;
  assign fmt_done  = (state == FMT) && (fmt_idx == 2'd3);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= 1'b0;
    end else if (bram_core_we || fmt_done) begin
      dirty <= 1'b1;
    end else if (xfer_done) begin
      dirty <= 1'b0;
    end
  end
`endif

endmodule
